// File: rtl/div_pkg.sv
// -----------------------------------------------------------------------------
// div_pkg -- shared definitions for the iterative divider.
//   XLEN_DEFAULT : default operand/result width
//   state_t      : divider FSM state encoding (IDLE / CALC / DONE)
// -----------------------------------------------------------------------------
package div_pkg;

    localparam int XLEN_DEFAULT = 32;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        DONE = 2'b11
    } state_t;

endpackage

// File: rtl/div_step.sv
// -----------------------------------------------------------------------------
// div_step -- one restoring-division iteration (purely combinational).
//   rem      : partial remainder (magnitude)
//   quo      : dividend bits still to shift in / quotient bits collected so far
//   dvsr     : divisor magnitude
//   rem_next : partial remainder after this iteration
//   quo_next : quo shifted left with the new quotient bit in bit 0
// -----------------------------------------------------------------------------
module div_step
    import div_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic [XLEN-1:0] rem,
    input  logic [XLEN-1:0] quo,
    input  logic [XLEN-1:0] dvsr,
    output logic [XLEN-1:0] rem_next,
    output logic [XLEN-1:0] quo_next
);

    logic [XLEN:0] shifted;
    logic [XLEN:0] diff;
    logic          fits;

    // {rem, quo} << 1 : the top dividend bit moves into the remainder.
    assign shifted = {rem, quo[XLEN-1]};
    assign diff    = shifted - {1'b0, dvsr};

    // If the shifted remainder already has its top bit set it exceeds any
    // XLEN-bit divisor; otherwise the borrow in diff[XLEN] decides.
    assign fits = shifted[XLEN] | ~diff[XLEN];

    assign rem_next = fits ? diff[XLEN-1:0] : shifted[XLEN-1:0];
    assign quo_next = {quo[XLEN-2:0], fits};

endmodule

// File: rtl/div.sv
// -----------------------------------------------------------------------------
// div -- iterative restoring divider, signed (DIV/REM) and unsigned (DIVU/REMU).
//   clk_i       : clock, all state on rising edge
//   rst_i       : asynchronous active-high reset
//   a_i, b_i    : dividend / divisor, stable while req_i is high
//   signed_i    : 1 = two's-complement, 0 = unsigned
//   req_i       : level request, held until ready_o; dropping it aborts
//   ready_o     : one-cycle completion pulse
//   quotient_o  : quotient, valid with ready_o and held afterwards
//   remainder_o : remainder, valid with ready_o and held afterwards
// Divide-by-zero, signed overflow and zero dividend finish in two edges;
// everything else takes XLEN iterations.
// -----------------------------------------------------------------------------
module div
    import div_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    input  logic            signed_i,
    input  logic            req_i,
    output logic            ready_o,
    output logic [XLEN-1:0] quotient_o,
    output logic [XLEN-1:0] remainder_o
);

    localparam int              CW      = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

    state_t          state, state_next;
    logic [CW-1:0]   cnt;
    logic            armed;
    logic [XLEN-1:0] rem, quo, dvsr;
    logic            neg_q, neg_r;
    logic [XLEN-1:0] rem_next, quo_next;
    logic            load, calc_en, finish;

    // ---------------- operand preparation ----------------
    logic            a_neg, b_neg;
    logic [XLEN-1:0] a_mag, b_mag;
    logic            is_special;
    logic [XLEN-1:0] spec_q, spec_r;

    assign a_neg = signed_i & a_i[XLEN-1];
    assign b_neg = signed_i & b_i[XLEN-1];
    assign a_mag = a_neg ? -a_i : a_i;
    assign b_mag = b_neg ? -b_i : b_i;

    // NOTE: every signal driven here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        is_special = 1'b1;
        spec_q     = '0;
        spec_r     = '0;
        if (b_i == '0) begin
            spec_q = '1;
            spec_r = a_i;
        end else if (signed_i && a_i == MIN_INT && b_i == '1) begin
            spec_q = MIN_INT;
        end else if (a_i == '0) begin
            spec_q = '0;
        end else begin
            is_special = 1'b0;
        end
    end

    // ---------------- FSM: state register ----------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_next;
    end

    // ---------------- FSM: next state ----------------
    // A low req_i sends every state back to IDLE (abort), DONE included.
    always_comb begin
        state_next = IDLE;
        if (req_i) begin
            case (state)
                IDLE:    state_next = armed ? (is_special ? DONE : CALC) : IDLE;
                CALC:    state_next = (cnt == '0) ? DONE : CALC;
                DONE:    state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        load    = (state == IDLE) && req_i && armed;
        calc_en = (state == CALC) && req_i;
        finish  = (state == DONE) && req_i;
    end

    // A request is accepted only after req_i has been seen low, so a
    // request held past ready_o does not start a second operation.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)       armed <= 1'b1;
        else if (!req_i) armed <= 1'b1;
        else if (load)   armed <= 1'b0;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)                     cnt <= '0;
        else if (load)                 cnt <= CW'(XLEN - 1);
        else if (calc_en && cnt != '0) cnt <= cnt - 1'b1;
    end

    // ---------------- datapath ----------------
    div_step #(.XLEN(XLEN)) u_step (
        .rem      (rem),
        .quo      (quo),
        .dvsr     (dvsr),
        .rem_next (rem_next),
        .quo_next (quo_next)
    );

    // NOTE: these are plain registers, not a memory array, so they take the
    // asynchronous reset like every other flop.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rem   <= '0;
            quo   <= '0;
            dvsr  <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else if (load) begin
            dvsr <= b_mag;
            if (is_special) begin
                // Final result loaded directly; sign flags cleared so the
                // output correction passes it through untouched.
                rem   <= spec_r;
                quo   <= spec_q;
                neg_q <= 1'b0;
                neg_r <= 1'b0;
            end else begin
                rem   <= '0;
                quo   <= a_mag;
                neg_q <= a_neg ^ b_neg;
                neg_r <= a_neg;
            end
        end else if (calc_en) begin
            rem <= rem_next;
            quo <= quo_next;
        end
    end

    // ---------------- output registers ----------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ready_o     <= 1'b0;
            quotient_o  <= '0;
            remainder_o <= '0;
        end else begin
            ready_o <= finish;
            if (finish) begin
                quotient_o  <= neg_q ? -quo : quo;
                remainder_o <= neg_r ? -rem : rem;
            end
        end
    end

endmodule

// File: doc/div.md
DIV -- requirements
Module: div

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand/result width; only 32 is required to be supported.
REQ-002 SHALL have port clk_i  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port rst_i  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port a_i  input  XLEN  dividend, held stable while req_i high.
REQ-005 SHALL have port b_i  input  XLEN  divisor, held stable while req_i high.
REQ-006 SHALL have port signed_i  input  1  1 = two's-complement DIV/REM, 0 = unsigned DIVU/REMU, held with operands.
REQ-007 SHALL have port req_i  input  1  level request, held high until ready_o seen.
REQ-008 SHALL have port ready_o  output  1  registered one-cycle completion pulse.
REQ-009 SHALL have port quotient_o  output  XLEN  registered quotient, valid when ready_o high, held after.
REQ-010 SHALL have port remainder_o  output  XLEN  registered remainder, valid when ready_o high, held after.

Function
REQ-011 SHALL implement FSM states IDLE, CALC, DONE; any unused encoding SHALL go to IDLE.
REQ-012 SHALL, in IDLE with req_i high and armed flag set, load operands and clear armed; sampling edge = edge 1.
REQ-013 SHALL set armed when req_i is sampled low; armed is set out of reset.
REQ-014 SHALL, on a special case at edge 1, load the final result and go IDLE->DONE directly; ready_o rises after edge 2.
REQ-015 SHALL treat these as special cases: b_i=0 -> quotient all ones, remainder = a_i.
REQ-016 SHALL treat signed_i=1, a_i=0x80000000, b_i=0xFFFFFFFF as a special case -> quotient 0x80000000, remainder 0.
REQ-017 SHALL treat a_i=0 as a special case -> quotient 0, remainder 0.
REQ-018 SHALL otherwise go to CALC for exactly XLEN cycles, driven by a down-counter loaded with XLEN-1 that ends at 0.
REQ-019 SHALL then spend one cycle in DONE; ready_o rises after edge XLEN+2 (34).
REQ-020 SHALL, each CALC cycle, shift {partial remainder, dividend} left 1 bit and trial-subtract |divisor| using an XLEN+1-bit difference.
REQ-021 SHALL, on a non-negative difference, keep the difference and shift in quotient bit 1; otherwise restore and shift in 0.
REQ-022 SHALL, when signed_i=1, divide operand magnitudes.
REQ-023 SHALL negate the signed quotient iff operand signs differ.
REQ-024 SHALL give the signed remainder the dividend's sign.
REQ-025 SHALL apply sign correction combinationally when registering outputs in DONE.
REQ-026 SHALL, in DONE, register quotient_o/remainder_o and pulse ready_o for exactly one cycle; ready_o is 0 in all other cycles.
REQ-027 SHALL force the FSM to IDLE at the next edge if req_i is low in any state (abort).
REQ-028 SHALL, on abort, not pulse ready_o, leave quotient_o/remainder_o unchanged and discard partial state.
REQ-029 SHALL, if req_i stays high after ready_o, not restart until req_i has been low one cycle (armed rule).
REQ-030 SHALL give a simultaneous req_i fall and DONE cycle priority to the abort: no ready_o.

Reset
REQ-031 SHALL, on rst_i high asynchronously: state IDLE, ready_o 0, quotient_o 0, remainder_o 0, counter 0, armed 1, internal datapath regs 0.
REQ-032 SHALL, on reset mid-CALC, abandon the operation: no ready_o after deassertion until a new request.

Structure
REQ-033 SHALL place state encodings (IDLE=2'b00, CALC=2'b01, DONE=2'b11) and the XLEN default in the shared core package, not locally.
REQ-034 SHALL isolate the single restoring iteration (shift, trial subtract, select, quotient bit) as sub-module div_step; counter, FSM, sign handling and output registers remain in div.

Verification
REQ-035 SHALL cover unsigned 100/7, req held -> quotient 14, remainder 2, ready_o single pulse after edge 34.
REQ-036 SHALL cover signed -7/2 (0xFFFFFFF9, 2) -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF; unsigned same operands -> 0x7FFFFFFC, 1.
REQ-037 SHALL cover 5/0 both modes -> quotient 0xFFFFFFFF, remainder 5, ready_o after edge 2; signed 0x80000000/0xFFFFFFFF -> 0x80000000, 0, ready after edge 2.
REQ-038 SHALL cover 1000/3 with req_i dropped at edge 10 -> no ready_o, outputs keep prior values; then 9/4 -> 2, 1 after 34 edges.
REQ-039 SHALL cover req_i held after completion -> no second ready_o; drop req_i 1 cycle, re-raise -> new result after 34 edges.
REQ-040 SHALL cover rst_i pulsed asynchronously (between edges) mid-CALC -> outputs 0 immediately, no ready_o afterwards.
